// File: rtl/hazard_ctrl.sv
// Stall controller: Tuse/Tnew RAW hazard detection plus a mult/div busy countdown.
// Stall decision is combinational in the same cycle; md_cnt and stall_cycles are registered.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic [1:0]       tuse_rs_ID,
  input  logic [1:0]       tuse_rt_ID,
  input  logic [4:0]       a3_EX,
  input  logic [1:0]       tnew_EX,
  input  logic [4:0]       a3_MEM,
  input  logic [1:0]       tnew_MEM,
  input  logic             md_use_ID,
  input  logic             md_start_EX,
  input  logic             md_div_EX,
  output logic             stall,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt,
  output logic [31:0]      stall_cycles
);

  logic [CNT_W-1:0] r_md_cnt;
  logic [31:0]      r_stall_cycles;
  logic             w_stall_rs;
  logic             w_stall_rt;
  logic             w_stall_md;
  logic             w_md_busy;
  logic             w_stall;

  assign w_md_busy = (r_md_cnt != '0);

  // A source stalls only if the producer's result arrives later than the consumer needs it.
  assign w_stall_rs = (tuse_rs_ID != 2'd3) && (rs_ID != 5'd0) &&
                      (((rs_ID == a3_EX)  && (tnew_EX  > tuse_rs_ID)) ||
                       ((rs_ID == a3_MEM) && (tnew_MEM > tuse_rs_ID)));

  assign w_stall_rt = (tuse_rt_ID != 2'd3) && (rt_ID != 5'd0) &&
                      (((rt_ID == a3_EX)  && (tnew_EX  > tuse_rt_ID)) ||
                       ((rt_ID == a3_MEM) && (tnew_MEM > tuse_rt_ID)));

  assign w_stall_md = md_use_ID && (md_start_EX || w_md_busy);
  assign w_stall    = w_stall_rs | w_stall_rt | w_stall_md;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_md_cnt <= '0;
    end else if (md_start_EX) begin
      r_md_cnt <= md_div_EX ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
    end else if (w_stall) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall        = w_stall;
  assign pc_we        = ~w_stall;
  assign ifid_we      = ~w_stall;
  assign idex_flush   = w_stall;
  assign md_busy      = w_md_busy;
  assign md_cnt       = r_md_cnt;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall controller for the five-stage MIPS pipeline.
- Detects RAW hazards that forwarding cannot resolve, using the Tuse/Tnew comparison.
- Tracks the multi-cycle mult/div unit with a busy countdown.
- Drives the write-enable of the fetch stage's PC, the IF/ID register enable and the ID/EX bubble insert.
- Also keeps a stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu issues in EX.
- DIV_CYCLES, 10, busy cycles after a div/divu issues in EX.
- CNT_W, 4, width of the md countdown; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- rs_ID  in  5  rs field of the instruction in ID.
- rt_ID  in  5  rt field of the instruction in ID.
- tuse_rs_ID  in  2  cycles until rs is consumed (0..2); 3 = rs unused.
- tuse_rt_ID  in  2  same encoding, for rt.
- a3_EX  in  5  destination register of the instruction in EX; 0 = none.
- tnew_EX  in  2  cycles until the EX result is forwardable.
- a3_MEM  in  5  destination register of the instruction in MEM.
- tnew_MEM  in  2  cycles until the MEM result is forwardable.
- md_use_ID  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
- md_start_EX  in  1  mult/div issuing in EX this cycle.
- md_div_EX  in  1  1 = the issuing op is a div, 0 = a mult.
- stall  out  1  pipeline stall this cycle.
- pc_we  out  1  PC write enable to the fetch stage; equals ~stall.
- ifid_we  out  1  IF/ID register enable; equals ~stall.
- idex_flush  out  1  clear ID/EX to a nop; equals stall.
- md_busy  out  1  md unit is busy.
- md_cnt  out  CNT_W  remaining md busy cycles.
- stall_cycles  out  32  count of stalled cycles since reset.

Behaviour:
- Hazard terms (combinational, same cycle):
  - stall_rs = (tuse_rs_ID != 3) && (rs_ID != 0) && ((rs_ID == a3_EX && tnew_EX > tuse_rs_ID) || (rs_ID == a3_MEM && tnew_MEM > tuse_rs_ID)).
  - stall_rt: same rule with rt_ID and tuse_rt_ID.
  - stall_md = md_use_ID && (md_start_EX || md_busy).
  - stall = stall_rs | stall_rt | stall_md. This is the only logic path from inputs to stall.
- md countdown (registered):
  - When md_start_EX = 1, md_cnt <= (md_div_EX ? DIV_CYCLES : MULT_CYCLES).
  - Otherwise, when md_cnt != 0, md_cnt <= md_cnt - 1.
  - Otherwise md_cnt holds at 0.
  - md_busy = (md_cnt != 0), combinational from the register.
  - Timing: if the op starts in cycle T, md_busy is high for cycles T+1 .. T+N. An md-using instruction in ID stalls in cycles T .. T+N and advances in cycle T+N+1.
- md_start_EX while md_busy: the counter reloads (restart). This cannot occur in legal flow, but the behaviour is defined.
- stall_cycles:
  - Increments by 1 at each rising edge where stall = 1.
  - Wraps from 0xFFFFFFFF to 0.
  - Holds otherwise.
- Reset (reset = 0, asynchronous):
  - md_cnt = 0, md_busy = 0, stall_cycles = 0 immediately, with no clock required.
  - Reset mid-countdown aborts the countdown.
  - During reset, stall follows the combinational terms with md_busy = 0.
  - Deassertion is synchronised externally; the counters first change on the first rising edge with reset = 1.
- Register $0 never causes a hazard.
- An a3 match with tnew = 0 never stalls.
- Simultaneous EX and MEM matches: stall if either term qualifies.

Test Plan:
- Load-use: lw $2 in EX (a3_EX = 2, tnew_EX = 2), add in ID (rs = 2, tuse_rs = 1) -> stall = 1, pc_we = 0, idex_flush = 1. Next cycle (a3_MEM = 2, tnew_MEM = 1) -> stall = 0.
- No hazard: rs_ID = 0 with a3_EX = 0, tnew_EX = 2 -> stall = 0. tuse_rs = 3 with a matching a3 -> stall = 0.
- mult then mflo:
  - md_start_EX = 1, md_div_EX = 0 at cycle T -> md_cnt = 5 at T+1, counting down to 0 at T+6.
  - With md_use_ID held at 1, stall = 1 for cycles T .. T+5 and 0 at T+6.
  - stall_cycles increments by 6.
- div: md_div_EX = 1 -> md_cnt = 10, md_busy high for exactly 10 cycles. A non-md instruction in ID during this time -> stall = 0.
- Reset mid-op: drive reset = 0 while md_cnt = 7 between clock edges -> md_cnt = 0, md_busy = 0, stall_cycles = 0 before the next edge.
- Counter wrap: force stall_cycles near 0xFFFFFFFF, apply one stalled cycle -> stall_cycles = 0.
